cc_scheduler: RTL and testbench

//  Sequences one frame of cross-correlation across three cc_1 cores sharing reference channel A.

---
 rtl/cc_pkg.sv | 21 ++
 rtl/cc_done_collector.sv | 47 ++++
 rtl/cc_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_cc_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// cc_pkg
//   Shared definitions for the cross-correlation scheduler and the
//   localisation stage that consumes its lag results.
//   - Datapath widths: sample, lag index, sample RAM address.
//   - Scheduler state encoding.
package cc_pkg;

  localparam int SAMPLE_W = 16;  // sample width, per channel
  localparam int TAU_W    = 16;  // signed lag index width from a cc_1 core
  localparam int ADDR_W   = 18;  // sample RAM address width
  localparam int N_CORES  = 3;   // cores pairing channel A with B, C, D

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LATCH  = 3'd4
  } cc_state_e;

endpackage

// File: rtl/cc_done_collector.sv
// cc_done_collector
//   One sticky flag per correlation core. A flag is set by its done input
//   on any enabled cycle and stays set until cleared.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     clr        clears all flags (takes priority)
//     en         done inputs are only honoured while en is high
//     done       per-core done strobes
//     all_done   every flag is set, or is being set this cycle
module cc_done_collector
  import cc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [N_CORES-1:0] done,
  output logic               all_done
);

  logic [N_CORES-1:0] flags_reg;
  logic [N_CORES-1:0] set_now;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_flag
      logic flag_reg;

      assign set_now[gi] = en & done[gi];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          flag_reg <= 1'b0;
        end else if (set_now[gi]) begin
          flag_reg <= 1'b1;
        end
      end

      assign flags_reg[gi] = flag_reg;
    end
  endgenerate

  // Including this cycle's strobes lets a done that arrives on the last
  // timeout cycle still complete the frame.
  assign all_done = &(flags_reg | set_now);

endmodule

// File: rtl/cc_scheduler.sv
// cc_scheduler
//   Sequences one frame of cross-correlation across three cc_1 cores that
//   share reference channel A (cores pair A with B, C and D). On go it
//   pulses cc_start, streams N_SAMPLES words from the 4-channel sample RAM,
//   waits for all three cores to finish (bounded by TIMEOUT cycles) and
//   latches their lag indices.
//   Ports:
//     clk, rst             system clock, synchronous active-high reset
//     go, base_addr        frame request (IDLE only) and first sample address
//     busy                 high in every state except IDLE
//     mem_addr             sample RAM read address
//     mem_a..mem_d         sample RAM data, channels A..D
//     cc_start             start pulse to all cores
//     cc_m0, cc_m1_b/c/d   samples forwarded to the cores
//     cc_done              per-core done flags (bit i = core i+1)
//     cc_index0..2         lag index from cores 1..3
//     tau1..3              lags of the last good frame
//     result_valid         1-cycle pulse: tau1..3 updated
//     timeout_err          1-cycle pulse: frame aborted in WAIT
module cc_scheduler
  import cc_pkg::*;
#(
  parameter int N_SAMPLES = 1024,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_a,
  input  logic [SAMPLE_W-1:0] mem_b,
  input  logic [SAMPLE_W-1:0] mem_c,
  input  logic [SAMPLE_W-1:0] mem_d,
  output logic                cc_start,
  output logic [SAMPLE_W-1:0] cc_m0,
  output logic [SAMPLE_W-1:0] cc_m1_b,
  output logic [SAMPLE_W-1:0] cc_m1_c,
  output logic [SAMPLE_W-1:0] cc_m1_d,
  input  logic [N_CORES-1:0]  cc_done,
  input  logic [TAU_W-1:0]    cc_index0,
  input  logic [TAU_W-1:0]    cc_index1,
  input  logic [TAU_W-1:0]    cc_index2,
  output logic [TAU_W-1:0]    tau1,
  output logic [TAU_W-1:0]    tau2,
  output logic [TAU_W-1:0]    tau3,
  output logic                result_valid,
  output logic                timeout_err
);

  localparam int K_W = $clog2(N_SAMPLES + 1);
  localparam int T_W = $clog2(TIMEOUT + 1);

  cc_state_e         state_reg, state_next;
  logic [K_W-1:0]    k_reg, k_next;
  logic [T_W-1:0]    wait_reg, wait_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic start_c, valid_c, timeout_c;
  logic flags_clr, flags_en, all_done;

  cc_done_collector u_done (
    .clk      (clk),
    .rst      (rst),
    .clr      (flags_clr),
    .en       (flags_en),
    .done     (cc_done),
    .all_done (all_done)
  );

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    wait_next  = wait_reg;
    addr_next  = addr_reg;
    start_c    = 1'b0;
    valid_c    = 1'b0;
    timeout_c  = 1'b0;
    flags_clr  = 1'b0;
    flags_en   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          state_next = ST_START;
          addr_next  = base_addr;   // START presents the base address
          k_next     = '0;
          flags_clr  = 1'b1;
        end
      end

      ST_START: begin
        start_c    = 1'b1;
        state_next = ST_STREAM;
        k_next     = K_W'(1);
        addr_next  = addr_reg + ADDR_W'(1);
      end

      ST_STREAM: begin
        flags_en = 1'b1;
        if (k_reg == K_W'(N_SAMPLES - 1)) begin
          state_next = ST_WAIT;
          wait_next  = '0;
        end else begin
          k_next    = k_reg + K_W'(1);
          addr_next = addr_reg + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        end
      end

      ST_WAIT: begin
        flags_en = 1'b1;
        if (all_done) begin
          state_next = ST_LATCH;
        end else if (wait_reg == T_W'(TIMEOUT - 1)) begin
          timeout_c  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wait_next = wait_reg + T_W'(1);
        end
      end

      ST_LATCH: begin
        valid_c    = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      wait_reg  <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      wait_reg  <= wait_next;
      addr_reg  <= addr_next;
    end
  end

  // The RAM word for the address issued this cycle is captured here, so
  // sample k reaches the cores one cycle after its address. The outputs
  // hold their last value once streaming ends.
  logic fwd_en;
  assign fwd_en = (state_reg == ST_START) || (state_reg == ST_STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_m0   <= '0;
      cc_m1_b <= '0;
      cc_m1_c <= '0;
      cc_m1_d <= '0;
    end else if (fwd_en) begin
      cc_m0   <= mem_a;
      cc_m1_b <= mem_b;
      cc_m1_c <= mem_c;
      cc_m1_d <= mem_d;
    end
  end

  // Lag capture happens in LATCH only; cores hold their index after done.
  logic [TAU_W-1:0] index_in [N_CORES];
  logic [TAU_W-1:0] tau_arr  [N_CORES];

  assign index_in[0] = cc_index0;
  assign index_in[1] = cc_index1;
  assign index_in[2] = cc_index2;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_tau
      logic [TAU_W-1:0] tau_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          tau_reg <= '0;
        end else if (state_reg == ST_LATCH) begin
          tau_reg <= index_in[gi];
        end
      end

      assign tau_arr[gi] = tau_reg;
    end
  endgenerate

  assign tau1 = tau_arr[0];
  assign tau2 = tau_arr[1];
  assign tau3 = tau_arr[2];

  // Pulses are suppressed while reset is asserted so an aborted frame
  // never reports anything.
  assign busy         = (state_reg != ST_IDLE);
  assign mem_addr     = addr_reg;
  assign cc_start     = start_c & ~rst;
  assign result_valid = valid_c & ~rst;
  assign timeout_err  = timeout_c & ~rst;

endmodule

// File: tb/tb_cc_scheduler.sv
// tb_cc_scheduler
//   Directed bench for cc_scheduler with N_SAMPLES=8 and TIMEOUT=16.
//   The sample RAM is modelled as a fixed function of the address; the
//   cores are modelled by per-frame done-strobe cycles and index values.
//   Cycle c counts from the START cycle S (c=0).
module tb_cc_scheduler;

  localparam int N   = 8;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [17:0] base_addr;
  logic        busy;
  logic [17:0] mem_addr;
  logic [15:0] mem_a, mem_b, mem_c, mem_d;
  logic        cc_start;
  logic [15:0] cc_m0, cc_m1_b, cc_m1_c, cc_m1_d;
  logic [2:0]  cc_done;
  logic [15:0] cc_index0, cc_index1, cc_index2;
  logic [15:0] tau1, tau2, tau3;
  logic        result_valid;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] sa(input logic [17:0] a);
    return a[15:0] ^ 16'h1234;
  endfunction
  function automatic logic [15:0] sb(input logic [17:0] a);
    return ~a[15:0];
  endfunction
  function automatic logic [15:0] sc(input logic [17:0] a);
    return a[15:0] + 16'h0100;
  endfunction
  function automatic logic [15:0] sd(input logic [17:0] a);
    return {a[7:0], a[15:8]} ^ {14'h0, a[17:16]};
  endfunction

  assign mem_a = sa(mem_addr);
  assign mem_b = sb(mem_addr);
  assign mem_c = sc(mem_addr);
  assign mem_d = sd(mem_addr);

  cc_scheduler #(.N_SAMPLES(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .base_addr    (base_addr),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_a        (mem_a),
    .mem_b        (mem_b),
    .mem_c        (mem_c),
    .mem_d        (mem_d),
    .cc_start     (cc_start),
    .cc_m0        (cc_m0),
    .cc_m1_b      (cc_m1_b),
    .cc_m1_c      (cc_m1_c),
    .cc_m1_d      (cc_m1_d),
    .cc_done      (cc_done),
    .cc_index0    (cc_index0),
    .cc_index1    (cc_index1),
    .cc_index2    (cc_index2),
    .tau1         (tau1),
    .tau2         (tau2),
    .tau3         (tau3),
    .result_valid (result_valid),
    .timeout_err  (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame. d1..d3: cycle (relative to S) of each core's done strobe,
  // -1 = never. exp_rv / exp_to: cycle of result_valid / timeout_err,
  // -1 = must not occur. e1..e3: tau values expected after the frame.
  task automatic run_frame(input string name, input logic [17:0] base,
                           input int d1, input int d2, input int d3,
                           input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] x3,
                           input int exp_rv, input int exp_to,
                           input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                           input bit go_mid);
    int rv_n;
    int to_n;
    int end_c;
    logic [17:0] ea;
    logic [17:0] last_a;
    rv_n  = 0;
    to_n  = 0;
    end_c = -1;
    cc_index0 = x1;
    cc_index1 = x2;
    cc_index2 = x3;
    base_addr = base;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) tick();
      cc_done = {(c == d3), (c == d2), (c == d1)};
      go = go_mid && (c == 3);
      #1;
      if (c == 0) check({name, " cc_start S"}, {31'd0, cc_start}, 32'd1);
      else if (c <= N) check({name, " cc_start low"}, {31'd0, cc_start}, 32'd0);
      if (c < N) begin
        ea = base + 18'(c);
        check({name, " mem_addr"}, {14'd0, mem_addr}, {14'd0, ea});
      end
      if (c >= 1 && c <= N) begin
        ea = base + 18'(c - 1);
        check({name, " cc_m0"},   {16'd0, cc_m0},   {16'd0, sa(ea)});
        check({name, " cc_m1_b"}, {16'd0, cc_m1_b}, {16'd0, sb(ea)});
        check({name, " cc_m1_c"}, {16'd0, cc_m1_c}, {16'd0, sc(ea)});
        check({name, " cc_m1_d"}, {16'd0, cc_m1_d}, {16'd0, sd(ea)});
      end
      if (result_valid) begin
        rv_n++;
        check({name, " result_valid cycle"}, c, exp_rv);
      end
      if (timeout_err) begin
        to_n++;
        check({name, " timeout_err cycle"}, c, exp_to);
      end
      if (c > 0 && !busy) begin
        end_c = c;
        break;
      end
    end
    cc_done = 3'b000;
    go = 1'b0;
    check({name, " result_valid count"}, rv_n, (exp_rv >= 0) ? 1 : 0);
    check({name, " timeout_err count"}, to_n, (exp_to >= 0) ? 1 : 0);
    check({name, " busy fall cycle"}, end_c, ((exp_rv >= 0) ? exp_rv : exp_to) + 1);
    check({name, " tau1"}, {16'd0, tau1}, {16'd0, e1});
    check({name, " tau2"}, {16'd0, tau2}, {16'd0, e2});
    check({name, " tau3"}, {16'd0, tau3}, {16'd0, e3});
    last_a = base + 18'(N - 1);
    check({name, " cc_m0 hold"}, {16'd0, cc_m0}, {16'd0, sa(last_a)});
    tick();
    tick();
    check({name, " idle after"}, {31'd0, busy}, 32'd0);
    $display("frame %s: base=%0d result_valid=%0d timeout_err=%0d tau=%0d,%0d,%0d",
             name, base, rv_n, to_n, $signed(tau1), $signed(tau2), $signed(tau3));
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    base_addr = '0;
    cc_done = 3'b000;
    cc_index0 = '0;
    cc_index1 = '0;
    cc_index2 = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset busy",         {31'd0, busy},         32'd0);
    check("reset cc_start",     {31'd0, cc_start},     32'd0);
    check("reset mem_addr",     {14'd0, mem_addr},     32'd0);
    check("reset cc_m0",        {16'd0, cc_m0},        32'd0);
    check("reset tau1",         {16'd0, tau1},         32'd0);
    check("reset tau2",         {16'd0, tau2},         32'd0);
    check("reset tau3",         {16'd0, tau3},         32'd0);
    check("reset result_valid", {31'd0, result_valid}, 32'd0);
    check("reset timeout_err",  {31'd0, timeout_err},  32'd0);
    $display("reset: busy=%0d mem_addr=%0d", busy, mem_addr);

    // Normal frame: WAIT from c=8, all done at c=12 -> LATCH at c=13.
    run_frame("normal", 18'd0, 12, 12, 12, 16'd5, 16'hFFFD, 16'd7,
              13, -1, 16'd5, 16'hFFFD, 16'd7, 1'b0);

    // Address wrap: 262140..262143 then 0..3. Last done c=11 -> rv at 12.
    run_frame("wrap", 18'h3FFFC, 10, 9, 11, 16'd1, 16'd2, 16'd3,
              12, -1, 16'd1, 16'd2, 16'd3, 1'b0);

    // Core 2 done during STREAM (c=4), cores 1/3 later; last at c=15.
    run_frame("stagger", 18'd500, 9, 4, 15, 16'd100, 16'hFF38, 16'd300,
              16, -1, 16'd100, 16'hFF38, 16'd300, 1'b0);

    // All done during STREAM: WAIT (c=8) completes at once -> rv at 9.
    // A go pulse at c=3 must be ignored.
    run_frame("early_go_busy", 18'd40, 2, 3, 5, 16'd10, 16'd20, 16'd30,
              9, -1, 16'd10, 16'd20, 16'd30, 1'b1);

    // Core 3 never done: WAIT c=8..23, timeout_err at c=23; tau unchanged.
    run_frame("timeout", 18'd7, 9, 10, -1, 16'd99, 16'd99, 16'd99,
              -1, 23, 16'd10, 16'd20, 16'd30, 1'b0);

    // Last done on the final timeout cycle: done wins, LATCH at c=24.
    run_frame("done_wins", 18'd64, 9, 10, 23, 16'd41, 16'd42, 16'd43,
              24, -1, 16'd41, 16'd42, 16'd43, 1'b0);

    // Reset held 3 cycles in the middle of STREAM.
    base_addr = 18'd200;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (3) tick();
    check("midrst busy before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("midrst no result_valid", {31'd0, result_valid}, 32'd0);
      check("midrst no timeout_err",  {31'd0, timeout_err},  32'd0);
      check("midrst no cc_start",     {31'd0, cc_start},     32'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    check("midrst busy",         {31'd0, busy},         32'd0);
    check("midrst cc_start",     {31'd0, cc_start},     32'd0);
    check("midrst mem_addr",     {14'd0, mem_addr},     32'd0);
    check("midrst tau1",         {16'd0, tau1},         32'd0);
    check("midrst result_valid", {31'd0, result_valid}, 32'd0);
    $display("midstream reset: busy=%0d mem_addr=%0d tau1=%0d", busy, mem_addr, tau1);

    run_frame("after_reset", 18'd100, 12, 12, 12, 16'd1, 16'd1, 16'd1,
              13, -1, 16'd1, 16'd1, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
